// File: rtl/wb_sram_ctrl.sv
// wb_sram_ctrl: Wishbone classic slave driving an asynchronous 32-bit SRAM bank.
// Each bus request becomes a timed SRAM read or write with programmable wait
// states, answered by a single-cycle registered ack. If cyc drops mid-cycle,
// the SRAM access still runs to completion and only the ack is suppressed.
module wb_sram_ctrl #(
  parameter int ADDR_WIDTH = 20,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [31:0]           sram_data_i,
  output logic [31:0]           sram_data_o,
  output logic                  sram_data_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, WRITE_HOLD, DONE} state_t;

  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_WAIT - 1);

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic                  r_abort, w_abort_nxt;
  logic                  r_ack, w_ack_nxt;
  logic [31:0]           r_dat, w_dat_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [31:0]           r_wdata, w_wdata_nxt;
  logic                  r_data_oe, w_data_oe_nxt;
  logic                  r_ce_n, w_ce_n_nxt;
  logic                  r_oe_n, w_oe_n_nxt;
  logic                  r_we_n, w_we_n_nxt;
  logic [3:0]            r_be_n, w_be_n_nxt;
  logic                  w_abort;
  logic                  w_unused_adr;

  // Abort is sticky once cyc drops inside an SRAM cycle.
  assign w_abort      = r_abort | ~wb_cyc_i;
  // Bank decoding is done by the arbiter, so upper and byte-lane bits are unused.
  assign w_unused_adr = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

  // Next-state and next-output decode for the SRAM cycle sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_abort_nxt   = r_abort;
    w_ack_nxt     = 1'b0;
    w_dat_nxt     = r_dat;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_data_oe_nxt = r_data_oe;
    w_ce_n_nxt    = r_ce_n;
    w_oe_n_nxt    = r_oe_n;
    w_we_n_nxt    = r_we_n;
    w_be_n_nxt    = r_be_n;
    unique case (r_state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          w_addr_nxt  = wb_adr_i[ADDR_WIDTH+1:2];
          w_wdata_nxt = wb_dat_i;
          w_ce_n_nxt  = 1'b0;
          w_abort_nxt = 1'b0;
          if (wb_we_i) begin
            w_state_nxt   = WRITE;
            w_cnt_nxt     = WR_LOAD;
            w_data_oe_nxt = 1'b1;
            // An all-zero select still runs the timed cycle but never strobes we_n.
            w_we_n_nxt    = (wb_sel_i == 4'b0000);
            w_be_n_nxt    = ~wb_sel_i;
          end else begin
            w_state_nxt = READ;
            w_cnt_nxt   = RD_LOAD;
            w_oe_n_nxt  = 1'b0;
            w_be_n_nxt  = 4'b0000;
          end
        end
      end
      READ: begin
        w_abort_nxt = w_abort;
        if (r_cnt == 4'd0) begin
          w_ce_n_nxt = 1'b1;
          w_oe_n_nxt = 1'b1;
          w_be_n_nxt = 4'hF;
          if (w_abort) begin
            w_state_nxt = IDLE;
          end else begin
            w_dat_nxt   = sram_data_i;
            w_ack_nxt   = 1'b1;
            w_state_nxt = DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      WRITE: begin
        w_abort_nxt = w_abort;
        if (r_cnt == 4'd0) begin
          w_we_n_nxt  = 1'b1;
          w_state_nxt = WRITE_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      WRITE_HOLD: begin
        // Data and chip enable were held one extra cycle for SRAM hold time.
        w_ce_n_nxt    = 1'b1;
        w_data_oe_nxt = 1'b0;
        w_be_n_nxt    = 4'hF;
        w_abort_nxt   = w_abort;
        if (w_abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_ack_nxt   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Ack is high here; IDLE is entered without sampling so a held stb is not re-run.
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_abort   <= 1'b0;
      r_ack     <= 1'b0;
      r_dat     <= 32'h0;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
      r_data_oe <= 1'b0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_be_n    <= 4'hF;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_abort   <= w_abort_nxt;
      r_ack     <= w_ack_nxt;
      r_dat     <= w_dat_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_ce_n    <= w_ce_n_nxt;
      r_oe_n    <= w_oe_n_nxt;
      r_we_n    <= w_we_n_nxt;
      r_be_n    <= w_be_n_nxt;
    end
  end

  assign wb_dat_o     = r_dat;
  assign wb_ack_o     = r_ack;
  assign wb_err_o     = 1'b0;
  assign wb_rty_o     = 1'b0;
  assign sram_addr    = r_addr;
  assign sram_data_o  = r_wdata;
  assign sram_data_oe = r_data_oe;
  assign sram_ce_n    = r_ce_n;
  assign sram_oe_n    = r_oe_n;
  assign sram_we_n    = r_we_n;
  assign sram_be_n    = r_be_n;

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Directed bench for wb_sram_ctrl: instance 0 uses READ_WAIT=2/WRITE_WAIT=2,
// instance 1 uses READ_WAIT=1/WRITE_WAIT=4. Each has its own SRAM model.
// Read results are checked against a shadow memory through a scoreboard queue.
module tb_wb_sram_ctrl;
  localparam int AW = 20;

  typedef struct {
    int          which;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc;
  logic        stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;

  logic [31:0]   dat_o [2];
  logic [1:0]    ack, err, rty, doe, ce_n, oe_n, we_n;
  logic [AW-1:0] saddr [2];
  logic [31:0]   sdi [2];
  logic [31:0]   sdo [2];
  logic [3:0]    be_n [2];

  logic [31:0] mem    [2][1024];
  logic [31:0] shadow [2][1024];
  exp_t        sb_q[$];

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int we_low [2];
  int oe_low [2];
  int doe_cnt[2];
  int acc    [2];
  int ack_cnt[2];
  logic [3:0] last_be [2];
  logic [1:0] prev_ce = 2'b11;

  always #5 clk = ~clk;

  wb_sram_ctrl #(.ADDR_WIDTH(AW), .READ_WAIT(2), .WRITE_WAIT(2)) u_dut_a (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat_o[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_rty_o(rty[0]), .sram_addr(saddr[0]),
    .sram_data_i(sdi[0]), .sram_data_o(sdo[0]), .sram_data_oe(doe[0]),
    .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]), .sram_be_n(be_n[0])
  );

  wb_sram_ctrl #(.ADDR_WIDTH(AW), .READ_WAIT(1), .WRITE_WAIT(4)) u_dut_b (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat_o[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_rty_o(rty[1]), .sram_addr(saddr[1]),
    .sram_data_i(sdi[1]), .sram_data_o(sdo[1]), .sram_data_oe(doe[1]),
    .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]), .sram_be_n(be_n[1])
  );

  // Asynchronous SRAM models: combinational read, byte-masked write while we_n is low.
  assign sdi[0] = (!ce_n[0] && !oe_n[0]) ? mem[0][saddr[0][9:0]] : 32'h0;
  assign sdi[1] = (!ce_n[1] && !oe_n[1]) ? mem[1][saddr[1][9:0]] : 32'h0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (!ce_n[i] && !we_n[i])
        for (int b = 0; b < 4; b++)
          if (!be_n[i][b]) mem[i][saddr[i][9:0]][b*8 +: 8] <= sdo[i][b*8 +: 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // Bus/SRAM monitor: activity counters, protocol invariants, scoreboard on ack.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!we_n[i]) begin we_low[i]++; last_be[i] = be_n[i]; end
      if (!oe_n[i]) oe_low[i]++;
      if (doe[i]) doe_cnt[i]++;
      if (!we_n[i] && !oe_n[i]) viol++;
      if (doe[i] && !oe_n[i]) viol++;
      if (!ce_n[i] && prev_ce[i]) acc[i]++;
      prev_ce[i] = ce_n[i];
      if (ack[i] === 1'b1) begin
        ack_cnt[i]++;
        check("sb_ack_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_dut", 32'(i), 32'(e.which));
          if (e.rd) check("sb_rdata", dat_o[i], e.data);
        end
      end
    end
  end

  task automatic clr(input int w);
    we_low[w] = 0; oe_low[w] = 0; doe_cnt[w] = 0; acc[w] = 0;
  endtask

  // One bus transaction; lat = clock edges from stb sample edge to seeing ack.
  task automatic xfer(input int w, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit hold, output int lat);
    cyc[w] = 1'b1; stb = 1'b1; we = wr; adr = a; wdat = d; sel = s;
    if (wr) begin
      shadow[w][a[11:2]] = merge(shadow[w][a[11:2]], d, s);
      sb_q.push_back('{w, 1'b0, 32'h0});
    end else begin
      sb_q.push_back('{w, 1'b1, shadow[w][a[11:2]]});
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ack[w] !== 1'b1 && lat < 40);
    @(posedge clk); #1;
    check("ack_width", 32'(ack[w]), 32'd0);
    if (!hold) begin cyc[w] = 1'b0; stb = 1'b0; end
  endtask

  initial begin
    int lat;
    int n_ack;
    rst = 1'b0; cyc = 2'b00; stb = 1'b0; we = 1'b0; adr = 32'h0; wdat = 32'h0; sel = 4'h0;
    for (int i = 0; i < 2; i++) begin
      clr(i); ack_cnt[i] = 0; last_be[i] = 4'hF;
      for (int k = 0; k < 1024; k++) begin
        mem[i][k]    <= 32'h5A00_0000 ^ 32'(k * 32'h0001_0103);
        shadow[i][k]  = 32'h5A00_0000 ^ 32'(k * 32'h0001_0103);
      end
    end
    mem[0][16] <= 32'hDEADBEEF; shadow[0][16] = 32'hDEADBEEF;
    mem[0][17] <= 32'hAABBCCDD; shadow[0][17] = 32'hAABBCCDD;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack[0]), 32'd0);
    check("rst_dat_o", dat_o[0], 32'h0);
    check("rst_ce_n", 32'(ce_n[0]), 32'd1);
    check("rst_oe_n", 32'(oe_n[0]), 32'd1);
    check("rst_we_n", 32'(we_n[0]), 32'd1);
    check("rst_be_n", 32'(be_n[0]), 32'hF);
    check("rst_data_oe", 32'(doe[0]), 32'd0);
    check("rst_addr", 32'(saddr[0]), 32'h0);
    check("rst_data_o", sdo[0], 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single read of word 0x10
    clr(0);
    xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, lat);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_oe_low", 32'(oe_low[0]), 32'd2);
    check("rd_dat_o", dat_o[0], 32'hDEADBEEF);

    // Byte-lane write then readback
    clr(0);
    xfer(0, 1'b1, 32'h44, 32'h11223344, 4'b0100, 1'b0, lat);
    check("wr_latency", 32'(lat), 32'd4);
    check("wr_we_low", 32'(we_low[0]), 32'd2);
    check("wr_data_oe", 32'(doe_cnt[0]), 32'd3);
    check("wr_be_n", 32'(last_be[0]), 32'b1011);
    xfer(0, 1'b0, 32'h44, 32'h0, 4'hF, 1'b0, lat);
    check("wr_readback", dat_o[0], 32'hAA22CCDD);

    // Refill burst with stb held high
    clr(0);
    n_ack = ack_cnt[0];
    for (int k = 0; k < 4; k++) begin
      xfer(0, 1'b0, 32'h100 + 32'(k * 4), 32'h0, 4'hF, (k != 3), lat);
      check("burst_latency", 32'(lat), 32'd3);
    end
    check("burst_acks", 32'(ack_cnt[0] - n_ack), 32'd4);
    check("burst_accesses", 32'(acc[0]), 32'd4);

    // Zero byte-select write: timing intact, we_n never strobes, data unchanged
    clr(0);
    xfer(0, 1'b1, 32'h44, 32'hFFFFFFFF, 4'b0000, 1'b0, lat);
    check("sel0_latency", 32'(lat), 32'd4);
    check("sel0_we_low", 32'(we_low[0]), 32'd0);
    xfer(0, 1'b0, 32'h44, 32'h0, 4'hF, 1'b0, lat);

    // Abort a read in its second cycle
    clr(0);
    n_ack = ack_cnt[0];
    cyc[0] = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[0] = 1'b0; stb = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_rd_no_ack", 32'(ack_cnt[0] - n_ack), 32'd0);
    check("abort_rd_oe_low", 32'(oe_low[0]), 32'd2);
    check("abort_rd_ce_n", 32'(ce_n[0]), 32'd1);
    xfer(0, 1'b0, 32'h44, 32'h0, 4'hF, 1'b0, lat);
    check("after_abort_latency", 32'(lat), 32'd3);

    // Abort a write right after it starts: write still completes in full
    clr(0);
    n_ack = ack_cnt[0];
    cyc[0] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h48; wdat = 32'hCAFEF00D; sel = 4'hF;
    shadow[0][18] = 32'hCAFEF00D;
    @(posedge clk); #1;
    cyc[0] = 1'b0; stb = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_wr_no_ack", 32'(ack_cnt[0] - n_ack), 32'd0);
    check("abort_wr_we_low", 32'(we_low[0]), 32'd2);
    check("abort_wr_data_oe", 32'(doe_cnt[0]), 32'd3);
    xfer(0, 1'b0, 32'h48, 32'h0, 4'hF, 1'b0, lat);

    // Reset asserted mid-write
    n_ack = ack_cnt[0];
    cyc[0] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h200; wdat = 32'h12345678; sel = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_we_n", 32'(we_n[0]), 32'd1);
    check("midrst_ce_n", 32'(ce_n[0]), 32'd1);
    check("midrst_data_oe", 32'(doe[0]), 32'd0);
    check("midrst_ack", 32'(ack[0]), 32'd0);
    cyc[0] = 1'b0; stb = 1'b0;
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_ack", 32'(ack_cnt[0] - n_ack), 32'd0);

    // Second instance: READ_WAIT=1, WRITE_WAIT=4
    clr(1);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, lat);
    check("b_rd_latency", 32'(lat), 32'd2);
    check("b_rd_oe_low", 32'(oe_low[1]), 32'd1);
    clr(1);
    xfer(1, 1'b1, 32'h80, 32'h0BADC0DE, 4'hF, 1'b0, lat);
    check("b_wr_latency", 32'(lat), 32'd6);
    check("b_wr_we_low", 32'(we_low[1]), 32'd4);
    check("b_wr_data_oe", 32'(doe_cnt[1]), 32'd5);
    xfer(1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b0, lat);
    check("b_wr_readback", dat_o[1], 32'h0BADC0DE);

    // Closing checks
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("we_oe_invariants", 32'(viol), 32'd0);
    check("err_rty_tied", {28'h0, err, rty}, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_sram_ctrl.md
Name: wb_sram_ctrl

Overview:
Wishbone classic slave that answers bus reads and writes, such as the 4-word instruction cache line refills, by driving an external asynchronous 32-bit SRAM. It sits behind the bus arbiter, one instance per SRAM bank.
Each bus request becomes a timed SRAM read or write cycle with programmable wait states, answered with a single-cycle ack. The master may hold cyc/stb high across back-to-back requests.

Parameters:
ADDR_WIDTH, 20, SRAM word-address width.
READ_WAIT, 2, cycles oe_n is held low before data is sampled (1..15).
WRITE_WAIT, 2, cycles we_n is held low (1..15).

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
wb_cyc_i  input  1  bus cycle
wb_stb_i  input  1  strobe
wb_we_i  input  1  1 = write
wb_adr_i  input  32  byte address; word address = bits [ADDR_WIDTH+1:2]
wb_dat_i  input  32  write data
wb_sel_i  input  4  byte enables
wb_dat_o  output  32  read data (registered)
wb_ack_o  output  1  single-cycle acknowledge (registered)
wb_err_o  output  1  tied 0
wb_rty_o  output  1  tied 0
sram_addr  output  ADDR_WIDTH  SRAM word address (registered)
sram_data_i  input  32  SRAM read data
sram_data_o  output  32  SRAM write data (registered)
sram_data_oe  output  1  1 = controller drives the data bus
sram_ce_n  output  1  chip enable, active low
sram_oe_n  output  1  output enable, active low
sram_we_n  output  1  write enable, active low
sram_be_n  output  4  byte enables, active low

Behaviour:
- Reset (rst==0 at a clk edge) forces the following on the next edge, including mid-transaction:
  - state=IDLE
  - wb_ack_o=0, wb_dat_o=0
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF
  - sram_data_oe=0, sram_addr=0, sram_data_o=0, wait counter=0
  - No ack is issued for the interrupted transaction.
- States: IDLE, READ, WRITE, WRITE_HOLD, DONE.
- IDLE:
  - cyc&stb sampled high: latch address, data and sel into sram_addr, sram_data_o and be.
  - Go to READ (we=0) or WRITE (we=1). Load counter with READ_WAIT-1 or WRITE_WAIT-1.
  - In READ: ce_n=0, oe_n=0, be_n=0000.
  - In WRITE: ce_n=0, data_oe=1, we_n=0, be_n=~sel.
- READ:
  - Counter decrements each cycle.
  - At count 0: register sram_data_i into wb_dat_o, deassert ce_n/oe_n, go to DONE.
  - READ therefore lasts exactly READ_WAIT cycles.
- WRITE:
  - Lasts exactly WRITE_WAIT cycles, then we_n=1 and go to WRITE_HOLD.
  - If sel==0000: we_n stays 1 for the whole write, but timing and ack are unchanged.
- WRITE_HOLD:
  - One cycle; data_oe and ce_n remain asserted (data hold time).
  - Then ce_n=1, data_oe=0, go to DONE.
- DONE:
  - wb_ack_o=1 for exactly this one cycle, then IDLE.
  - IDLE does not sample a request in the same cycle the ack is high, so a held stb never double-executes.
- Latency, stb sample edge to ack-high cycle:
  - Read: READ_WAIT+1 cycles.
  - Write: WRITE_WAIT+2 cycles.
  - Minimum gap between consecutive acks: 1 IDLE cycle.
- we_n and oe_n are never low in the same cycle.
- data_oe is 0 whenever oe_n=0.
- Abort: if cyc drops while in READ/WRITE/WRITE_HOLD:
  - The SRAM cycle completes with its normal timing; writes are never truncated.
  - DONE is skipped: no ack, return to IDLE.
- wb_dat_o holds the last read value until the next read completes.
- Address bits above ADDR_WIDTH+1 are ignored; decoding belongs to the arbiter.

Test Plan:
- Reset: hold rst=0 mid-WRITE -> next edge we_n=1, ce_n=1, data_oe=0, ack=0, no ack afterwards.
- Single read: SRAM model returns 32'hDEADBEEF at word 0x00010; read adr=0x40 -> ack exactly 3 cycles after sample (READ_WAIT=2), dat_o=DEADBEEF, oe_n low exactly 2 cycles.
- Byte write: adr=0x44, dat=0x11223344, sel=0100 -> be_n=1011, we_n low 2 cycles, data_oe high 3 cycles; readback gives only byte2=0x22 changed; ack after 4 cycles.
- Refill burst: stb held high for addrs 0x100,0x104,0x108,0x10C -> 4 acks, each with the correct word, each ack 1 cycle wide, no duplicate SRAM access.
- Abort: drop cyc in the second READ cycle -> no ack, FSM back in IDLE, next request serviced normally.
- Parameter sweep READ_WAIT=1, WRITE_WAIT=4 -> read latency 2, write latency 6; we_n/oe_n never simultaneously low (assertion).
